// File: rtl/cnn_layer_1_output_packer_pkg.sv
// Shared layer-1 geometry and word-width constants for the output packer and its FIFO.
package cnn_layer_1_output_packer_pkg;

   localparam int IMAGE_W  = 28;
   localparam int IMAGE_H  = 28;
   localparam int KERNEL_W = 5;
   localparam int KERNEL_H = 5;

   // Valid (no padding, stride 1) convolution output geometry
   localparam int L1_OUT_W = IMAGE_W - KERNEL_W + 1;
   localparam int L1_OUT_H = IMAGE_H - KERNEL_H + 1;

   localparam int FEATURE_BITWIDTH       = 8;
   localparam int CHANNEL_ACCUM_BITWIDTH = 22;
   localparam int L1_REQ_SHIFT           = 8;
   localparam int L1_OUT_CH              = 3;
   localparam int L1_FIFO_DEPTH          = 8;

endpackage

// File: rtl/cnn_layer_1_sync_fifo.sv
// Generic single-clock FIFO with combinational head read, full/empty flags and occupancy level.
module cnn_layer_1_sync_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clear,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_wr;
   logic             w_rd;

   assign full    = (r_level == (AW+1)'(DEPTH));
   assign empty   = (r_level == '0);
   assign level   = r_level;
   assign rd_data = r_mem[r_rd_ptr];

   // A write into a full FIFO is only legal when the head leaves in the same cycle
   assign w_rd = rd_en & ~empty;
   assign w_wr = wr_en & (~full | w_rd);

   always_ff @(posedge clk) begin
      if (w_wr && !clear)
         r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      end
   end

endmodule

// File: rtl/cnn_layer_1_output_packer.sv
// Requantises layer-1 conv results, tags row/col geometry and queues pixels for layer 2.
// Build option: define CNN_LAYER_1_OUT_ROUND_EN for round-half-up requantisation.
module cnn_layer_1_output_packer
   import cnn_layer_1_output_packer_pkg::*;
#(
   parameter int OUT_CH = L1_OUT_CH,
   parameter int ACC_W  = CHANNEL_ACCUM_BITWIDTH,
   parameter int FEAT_W = FEATURE_BITWIDTH,
   parameter int SHIFT  = L1_REQ_SHIFT,
   parameter int DEPTH  = L1_FIFO_DEPTH,
   parameter int OUT_W  = L1_OUT_W,
   parameter int OUT_H  = L1_OUT_H
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clear,
   input  logic                       result_valid,
   input  logic [OUT_CH*ACC_W-1:0]    output_feature,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [OUT_CH*FEAT_W-1:0]   m_data,
   output logic                       m_eol,
   output logic                       m_last,
   output logic                       frame_done,
   output logic                       overflow,
   output logic [$clog2(DEPTH):0]     fifo_level
);

   localparam int CW = $clog2(OUT_W);
   localparam int RW = $clog2(OUT_H);
   localparam int DW = OUT_CH * FEAT_W;
   localparam int EW = DW + 2;
   localparam logic [CW-1:0] COL_MAX = CW'(OUT_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(OUT_H - 1);

   logic [DW-1:0]  w_q;
   logic           w_eol;
   logic           w_last;
   logic [CW-1:0]  r_col;
   logic [RW-1:0]  r_row;
   logic           r_s1_valid;
   logic [DW-1:0]  r_s1_data;
   logic           r_s1_eol;
   logic           r_s1_last;
   logic           r_overflow;
   logic           r_frame_done;
   logic [EW-1:0]  w_head;
   logic           w_full;
   logic           w_empty;
   logic           w_pop;

   genvar gi;
   generate
      for (gi = 0; gi < OUT_CH; gi++) begin : g_req
         logic [ACC_W-1:0] w_x;
         logic [ACC_W:0]   w_sum;
         logic [ACC_W:0]   w_y;

         assign w_x = output_feature[gi*ACC_W +: ACC_W];
`ifdef CNN_LAYER_1_OUT_ROUND_EN
         localparam logic [ACC_W:0] RND = (ACC_W+1)'(1) << (SHIFT - 1);
         assign w_sum = {w_x[ACC_W-1], w_x} + RND;
`else
         assign w_sum = {w_x[ACC_W-1], w_x};
`endif
         // Sign is taken from the raw input so rounding can never lift a negative value above 0
         assign w_y = w_sum >> SHIFT;
         assign w_q[gi*FEAT_W +: FEAT_W] = w_x[ACC_W-1]          ? '0 :
                                           (|w_y[ACC_W:FEAT_W])  ? '1 :
                                                                   w_y[FEAT_W-1:0];
      end
   endgenerate

   assign w_eol  = (r_col == COL_MAX);
   assign w_last = w_eol & (r_row == ROW_MAX);

   // Geometry advances on every pulse, dropped or not, so tags stay frame-aligned
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_col      <= '0;
         r_row      <= '0;
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_eol   <= 1'b0;
         r_s1_last  <= 1'b0;
      end else if (clear) begin
         r_col      <= '0;
         r_row      <= '0;
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= result_valid;
         if (result_valid) begin
            r_s1_data <= w_q;
            r_s1_eol  <= w_eol;
            r_s1_last <= w_last;
            if (w_eol) begin
               r_col <= '0;
               r_row <= (r_row == ROW_MAX) ? '0 : r_row + RW'(1);
            end else begin
               r_col <= r_col + CW'(1);
            end
         end
      end
   end

   cnn_layer_1_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .wr_en   (r_s1_valid),
      .wr_data ({r_s1_last, r_s1_eol, r_s1_data}),
      .rd_en   (m_ready),
      .rd_data (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .level   (fifo_level)
   );

   assign w_pop = m_ready & ~w_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow   <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (clear) begin
         r_overflow   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         if (r_s1_valid && w_full && !w_pop)
            r_overflow <= 1'b1;
         r_frame_done <= w_pop & w_head[EW-1];
      end
   end

   assign m_valid    = ~w_empty;
   assign m_data     = w_head[DW-1:0];
   assign m_eol      = w_head[DW];
   assign m_last     = w_head[DW+1];
   assign overflow   = r_overflow;
   assign frame_done = r_frame_done;

endmodule
